ttt_turn_scheduler: RTL and testbench

Turn controller for the tic-tac-toe datapath.
- Pops player moves (ASCII digits) from the UART receive FIFO and takes computer moves from the switch/PC source.
- Validates each move against the current board and issues the single-cycle `play` / `pc` strobes plus positions to the game core.
- Tracks whose turn it is, counts moves and detects game end.
- Sits between the `uart` driver and `tic_tac_toe` in the top level, replacing the raw push-button enables.

---
 rtl/ttt_pkg.sv | 47 ++++
 rtl/ttt_move_check.sv | 49 ++++
 rtl/ttt_turn_scheduler.sv | 247 ++++++++++++++++++++++++
 tb/tb_ttt_turn_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe turn scheduler.
// Optional feature macro used by this slice: TTT_AUTO_PC_EN (computer auto-pick on timeout).
package ttt_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_P_WAIT,
        S_P_CHECK,
        S_P_COMMIT,
        S_C_WAIT,
        S_C_CHECK,
        S_C_COMMIT,
        S_OVER
    } state_t;

    // Per-cell board codes
    localparam logic [1:0] CELL_EMPTY  = 2'b00;
    localparam logic [1:0] CELL_PLAYER = 2'b01;
    localparam logic [1:0] CELL_PC     = 2'b10;

    // Game result codes from the game core
    localparam logic [1:0] WHO_NONE   = 2'b00;
    localparam logic [1:0] WHO_PLAYER = 2'b01;
    localparam logic [1:0] WHO_PC     = 2'b10;
    localparam logic [1:0] WHO_DRAW   = 2'b11;

    // Turn indication
    localparam logic [1:0] TURN_IDLE   = 2'b00;
    localparam logic [1:0] TURN_PLAYER = 2'b01;
    localparam logic [1:0] TURN_PC     = 2'b10;

    localparam logic [7:0] ASCII_ONE  = 8'h31;
    localparam logic [7:0] ASCII_NINE = 8'h39;

    localparam logic [3:0] MAX_MOVES = 4'd9;

    // Board code of cell pos (1..9); out-of-range positions read as empty
    function automatic logic [1:0] cell_at(input logic [17:0] board, input logic [3:0] pos);
        logic [1:0] code;
        code = CELL_EMPTY;
        for (int i = 1; i <= 9; i++) begin
            if (pos == 4'(i)) code = board[2*i-2 +: 2];
        end
        return code;
    endfunction

endpackage

// File: rtl/ttt_move_check.sv
// Combinational move checker shared by the player and computer turn paths:
// cell lookup, range check and (with TTT_AUTO_PC_EN) lowest-free-cell finder.
module ttt_move_check
    import ttt_pkg::*;
(
    input  logic [17:0] i_board,
    input  logic [7:0]  i_code,     // ASCII digit when i_ascii, else zero-extended cell number
    input  logic        i_ascii,
    output logic [3:0]  o_pos,
    output logic [1:0]  o_cell,
    output logic        o_valid
`ifdef TTT_AUTO_PC_EN
    ,
    output logic        o_free_found,
    output logic [3:0]  o_free_pos
`endif
);

    logic w_in_range;

    // Range check on the full code, then cell lookup; ASCII '1'..'9' carry the cell in the low nibble
    always_comb begin
        // NOTE: every output gets a default first so no path through the block can infer a latch.
        w_in_range = 1'b0;
        if (i_ascii) begin
            w_in_range = (i_code >= ASCII_ONE) && (i_code <= ASCII_NINE);
        end else begin
            w_in_range = (i_code >= 8'd1) && (i_code <= 8'd9);
        end
        o_pos   = i_code[3:0];
        o_cell  = cell_at(i_board, o_pos);
        o_valid = w_in_range && (o_cell == CELL_EMPTY);
    end

`ifdef TTT_AUTO_PC_EN
    // Scan from cell 9 down so the last hit is the lowest-numbered empty cell
    always_comb begin
        o_free_found = 1'b0;
        o_free_pos   = 4'd0;
        for (int i = 9; i >= 1; i--) begin
            if (i_board[2*i-2 +: 2] == CELL_EMPTY) begin
                o_free_found = 1'b1;
                o_free_pos   = 4'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/ttt_turn_scheduler.sv
// Turn controller between the UART RX FIFO / computer move source and the
// tic-tac-toe game core. Validates moves, issues play/pc strobes, tracks turn,
// move count and game end. All outputs are registered.
// Optional feature macro: TTT_AUTO_PC_EN -- computer auto-picks the lowest free
// cell after PC_TIMEOUT cycles in C_WAIT; without it C_WAIT waits indefinitely.
module ttt_turn_scheduler
    import ttt_pkg::*;
#(
    parameter int PC_TIMEOUT = 50_000_000,
    parameter int CNT_W      = 26
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        rx_empty,
    input  logic [7:0]  r_data,
    output logic        rd_uart,
    input  logic        pc_valid,
    input  logic [3:0]  pc_position,
    input  logic [17:0] board,
    input  logic [1:0]  who,
    output logic        play,
    output logic [3:0]  player_position,
    output logic        pc,
    output logic [3:0]  computer_position,
    output logic [1:0]  turn,
    output logic [3:0]  move_count,
    output logic        bad_move,
    output logic        game_over
);

    // Elaboration guard: the timeout counter must be able to hold PC_TIMEOUT
    if ((PC_TIMEOUT < 1) || ((PC_TIMEOUT >> CNT_W) != 0)) begin : g_cfg_check
        $error("CNT_W is too narrow for PC_TIMEOUT");
    end

    state_t      r_state, w_state_next;
    logic [7:0]  r_rx_byte, w_rx_byte_next;
    logic [3:0]  r_pc_req, w_pc_req_next;
    logic        r_rd_uart, w_rd_uart_next;
    logic        r_play, w_play_next;
    logic [3:0]  r_player_pos, w_player_pos_next;
    logic        r_pc, w_pc_next;
    logic [3:0]  r_computer_pos, w_computer_pos_next;
    logic [1:0]  r_turn, w_turn_next;
    logic [3:0]  r_move_count, w_move_count_next;
    logic        r_bad_move, w_bad_move_next;
    logic        r_game_over, w_game_over_next;

    logic [7:0]  w_chk_code;
    logic        w_chk_ascii;
    logic [3:0]  w_chk_pos;
    logic [1:0]  w_chk_cell;
    logic        w_chk_valid;
    logic [3:0]  w_count_inc;

`ifdef TTT_AUTO_PC_EN
    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(PC_TIMEOUT - 1);
    logic [CNT_W-1:0] r_pc_timer, w_pc_timer_next;
    logic             w_free_found;
    logic [3:0]       w_free_pos;
`endif

    assign w_count_inc = r_move_count + 4'd1;

    // Select what the shared checker looks at: the RX byte, the requested PC cell, or the cell being committed
    always_comb begin
        w_chk_code  = {4'd0, r_pc_req};
        w_chk_ascii = 1'b0;
        case (r_state)
            S_P_CHECK: begin
                w_chk_code  = r_rx_byte;
                w_chk_ascii = 1'b1;
            end
            S_P_COMMIT: w_chk_code = {4'd0, r_player_pos};
            S_C_COMMIT: w_chk_code = {4'd0, r_computer_pos};
            default: ;
        endcase
    end

    ttt_move_check u_move_check (
        .i_board      (board),
        .i_code       (w_chk_code),
        .i_ascii      (w_chk_ascii),
        .o_pos        (w_chk_pos),
        .o_cell       (w_chk_cell),
        .o_valid      (w_chk_valid)
`ifdef TTT_AUTO_PC_EN
        ,
        .o_free_found (w_free_found),
        .o_free_pos   (w_free_pos)
`endif
    );

    // Next-state and next-output logic; start overrides every other event
    always_comb begin
        w_state_next        = r_state;
        w_rx_byte_next      = r_rx_byte;
        w_pc_req_next       = r_pc_req;
        w_rd_uart_next      = 1'b0;
        w_play_next         = 1'b0;
        w_pc_next           = 1'b0;
        w_player_pos_next   = r_player_pos;
        w_computer_pos_next = r_computer_pos;
        w_move_count_next   = r_move_count;
        w_bad_move_next     = r_bad_move;
`ifdef TTT_AUTO_PC_EN
        w_pc_timer_next     = '0;
`endif
        if (start) begin
            w_state_next      = S_P_WAIT;
            w_move_count_next = 4'd0;
            w_bad_move_next   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: ;
                S_P_WAIT: begin
                    if (!rx_empty) begin
                        w_rx_byte_next = r_data;
                        w_rd_uart_next = 1'b1;
                        w_state_next   = S_P_CHECK;
                    end
                end
                S_P_CHECK: begin
                    if (w_chk_valid) begin
                        w_play_next       = 1'b1;
                        w_player_pos_next = w_chk_pos;
                        w_state_next      = S_P_COMMIT;
                    end else begin
                        w_bad_move_next = 1'b1;
                        w_state_next    = S_P_WAIT;
                    end
                end
                S_P_COMMIT: begin
                    if (w_chk_cell == CELL_PLAYER) begin
                        w_move_count_next = w_count_inc;
                        w_bad_move_next   = 1'b0;
                        w_state_next      = ((who != WHO_NONE) || (w_count_inc == MAX_MOVES))
                                            ? S_OVER : S_C_WAIT;
                    end
                end
                S_C_WAIT: begin
                    if (pc_valid) begin
                        w_pc_req_next = pc_position;
                        w_state_next  = S_C_CHECK;
                    end
`ifdef TTT_AUTO_PC_EN
                    else if (r_pc_timer == TIMER_LAST) begin
                        // Auto-pick behaves like an accepted computer move
                        if (w_free_found) begin
                            w_pc_next           = 1'b1;
                            w_computer_pos_next = w_free_pos;
                            w_state_next        = S_C_COMMIT;
                        end
                    end else begin
                        w_pc_timer_next = r_pc_timer + 1'b1;
                    end
`endif
                end
                S_C_CHECK: begin
                    if (w_chk_valid) begin
                        w_pc_next           = 1'b1;
                        w_computer_pos_next = w_chk_pos;
                        w_state_next        = S_C_COMMIT;
                    end else begin
                        w_bad_move_next = 1'b1;
                        w_state_next    = S_C_WAIT;
                    end
                end
                S_C_COMMIT: begin
                    if (w_chk_cell == CELL_PC) begin
                        w_move_count_next = w_count_inc;
                        w_bad_move_next   = 1'b0;
                        w_state_next      = ((who != WHO_NONE) || (w_count_inc == MAX_MOVES))
                                            ? S_OVER : S_P_WAIT;
                    end
                end
                S_OVER: ;
                default: w_state_next = S_IDLE;
            endcase
        end

        // Turn and game_over follow the state being entered so they stay aligned with it
        w_turn_next = TURN_IDLE;
        case (w_state_next)
            S_P_WAIT, S_P_CHECK, S_P_COMMIT: w_turn_next = TURN_PLAYER;
            S_C_WAIT, S_C_CHECK, S_C_COMMIT: w_turn_next = TURN_PC;
            default: ;
        endcase
        w_game_over_next = (w_state_next == S_OVER);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Registered outputs and move latches
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_byte      <= 8'd0;
            r_pc_req       <= 4'd0;
            r_rd_uart      <= 1'b0;
            r_play         <= 1'b0;
            r_player_pos   <= 4'd0;
            r_pc           <= 1'b0;
            r_computer_pos <= 4'd0;
            r_turn         <= TURN_IDLE;
            r_move_count   <= 4'd0;
            r_bad_move     <= 1'b0;
            r_game_over    <= 1'b0;
        end else begin
            r_rx_byte      <= w_rx_byte_next;
            r_pc_req       <= w_pc_req_next;
            r_rd_uart      <= w_rd_uart_next;
            r_play         <= w_play_next;
            r_player_pos   <= w_player_pos_next;
            r_pc           <= w_pc_next;
            r_computer_pos <= w_computer_pos_next;
            r_turn         <= w_turn_next;
            r_move_count   <= w_move_count_next;
            r_bad_move     <= w_bad_move_next;
            r_game_over    <= w_game_over_next;
        end
    end

`ifdef TTT_AUTO_PC_EN
    // Computer-move timeout counter; runs only while waiting in C_WAIT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_pc_timer <= '0;
        else       r_pc_timer <= w_pc_timer_next;
    end
`endif

    assign rd_uart           = r_rd_uart;
    assign play              = r_play;
    assign player_position   = r_player_pos;
    assign pc                = r_pc;
    assign computer_position = r_computer_pos;
    assign turn              = r_turn;
    assign move_count        = r_move_count;
    assign bad_move          = r_bad_move;
    assign game_over         = r_game_over;

endmodule

// File: tb/tb_ttt_turn_scheduler.sv
// Self-checking bench for ttt_turn_scheduler. The bench plays the game core:
// it keeps the board as an array of cells, writes marks after the strobes and
// computes the winner from the line rules. Expected scheduler behaviour comes
// from the move rules and cycle latencies of the turn protocol.
module tb_ttt_turn_scheduler;

    localparam int PC_TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        reset, start, rx_empty, pc_valid;
    logic [7:0]  r_data;
    logic [3:0]  pc_position;
    logic [17:0] board;
    logic [1:0]  who;
    logic        rd_uart, play, pc, bad_move, game_over;
    logic [3:0]  player_position, computer_position, move_count;
    logic [1:0]  turn;

    logic [1:0]  cells [1:9];
    int          mdl_count;
    bit          mdl_ok, mdl_over;
    int          n_tests = 0;
    int          n_fail  = 0;

    ttt_turn_scheduler #(.PC_TIMEOUT(PC_TIMEOUT), .CNT_W(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .rx_empty          (rx_empty),
        .r_data            (r_data),
        .rd_uart           (rd_uart),
        .pc_valid          (pc_valid),
        .pc_position       (pc_position),
        .board             (board),
        .who               (who),
        .play              (play),
        .player_position   (player_position),
        .pc                (pc),
        .computer_position (computer_position),
        .turn              (turn),
        .move_count        (move_count),
        .bad_move          (bad_move),
        .game_over         (game_over)
    );

    always #5 clk = ~clk;

    always_comb begin
        board = '0;
        for (int i = 1; i <= 9; i++) board[2*i-2 +: 2] = cells[i];
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: run did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Winner by line rules; draw when full without a line
    function automatic logic [1:0] winner();
        int lines [8][3] = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7},
                             '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};
        bit full = 1'b1;
        for (int l = 0; l < 8; l++) begin
            if (cells[lines[l][0]] != 2'b00 &&
                cells[lines[l][0]] == cells[lines[l][1]] &&
                cells[lines[l][1]] == cells[lines[l][2]])
                return cells[lines[l][0]];
        end
        for (int i = 1; i <= 9; i++) if (cells[i] == 2'b00) full = 1'b0;
        return full ? 2'b11 : 2'b00;
    endfunction

    function automatic int lowest_free();
        for (int i = 1; i <= 9; i++) if (cells[i] == 2'b00) return i;
        return 0;
    endfunction

    function automatic int random_free();
        int q[$];
        for (int i = 1; i <= 9; i++) if (cells[i] == 2'b00) q.push_back(i);
        if (q.size() == 0) return 1;
        return q[$urandom_range(0, q.size() - 1)];
    endfunction

    function automatic logic [7:0] rand_byte();
        case ($urandom_range(0, 9))
            6:       return 8'h30;
            7:       return 8'h41;
            8:       return 8'h0d;
            9:       return 8'h0a;
            default: return 8'(8'h31 + $urandom_range(0, 8));
        endcase
    endfunction

    task automatic check_reset_values(input string tag);
        check(tag, 32'({rd_uart, play, pc, player_position, computer_position,
                        turn, move_count, bad_move, game_over}), 32'd0);
    endtask

    // Game core writes the mark after delay cycles; scheduler must commit one cycle later
    task automatic commit(input logic [1:0] mark, input int pos, input int delay);
        bit over;
        repeat (delay) begin
            cycle();
            check("commit_hold_count", 32'(move_count), 32'(mdl_count));
            check("commit_no_pop", 32'(rd_uart), 32'd0);
        end
        cells[pos] = mark;
        who = winner();
        cycle();
        mdl_count++;
        over = (who != 2'b00) || (mdl_count == 9);
        mdl_over = over;
        check("commit_count", 32'(move_count), 32'(mdl_count));
        check("commit_bad_clr", 32'(bad_move), 32'd0);
        check("commit_turn", 32'(turn),
              over ? 32'd0 : ((mark == 2'b01) ? 32'd2 : 32'd1));
        check("commit_over", 32'(game_over), 32'(over));
    endtask

    task automatic player_move(input logic [7:0] b, input int delay);
        int p = 0;
        bit ok = 1'b0;
        if (b >= 8'h31 && b <= 8'h39) begin
            p  = int'(b) - 48;
            ok = (cells[p] == 2'b00);
        end
        mdl_ok = ok;
        rx_empty = 1'b0;
        r_data   = b;
        cycle();
        check("p_rd_uart", 32'(rd_uart), 32'd1);
        check("p_play_early", 32'(play), 32'd0);
        rx_empty = 1'b1;
        cycle();
        check("p_rd_uart_once", 32'(rd_uart), 32'd0);
        check("p_play", 32'(play), 32'(ok));
        if (ok) begin
            check("p_pos", 32'(player_position), 32'(p));
            commit(2'b01, p, delay);
        end else begin
            check("p_bad_move", 32'(bad_move), 32'd1);
            check("p_turn_stay", 32'(turn), 32'd1);
        end
    endtask

    task automatic pc_move(input int pos, input int delay, input bit pending);
        bit ok;
        ok = (pos >= 1 && pos <= 9) ? (cells[pos] == 2'b00) : 1'b0;
        mdl_ok = ok;
        rx_empty    = !pending;
        r_data      = 8'(8'h31 + $urandom_range(0, 8));
        pc_valid    = 1'b1;
        pc_position = 4'(pos);
        cycle();
        check("c_pc_early", 32'(pc), 32'd0);
        check("c_no_pop", 32'(rd_uart), 32'd0);
        pc_valid    = 1'b0;
        pc_position = 4'($urandom_range(0, 15));
        cycle();
        check("c_pc", 32'(pc), 32'(ok));
        check("c_no_pop2", 32'(rd_uart), 32'd0);
        if (ok) begin
            check("c_pos", 32'(computer_position), 32'(pos));
            commit(2'b10, pos, delay);
        end else begin
            check("c_bad_move", 32'(bad_move), 32'd1);
            check("c_turn_stay", 32'(turn), 32'd2);
        end
    endtask

    // Computer source stays silent for the whole turn
    task automatic pc_timeout_move(input int delay);
        bit seen = 1'b0;
        int p = lowest_free();
`ifdef TTT_AUTO_PC_EN
        repeat (PC_TIMEOUT - 1) begin
            cycle();
            seen |= pc;
        end
        check("to_no_early_pc", 32'(seen), 32'd0);
        cycle();
        check("to_pc", 32'(pc), 32'd1);
        check("to_pos", 32'(computer_position), 32'(p));
        mdl_ok = 1'b1;
        commit(2'b10, p, delay);
`else
        repeat (3 * PC_TIMEOUT) begin
            cycle();
            seen |= pc;
        end
        check("to_never_pc", 32'(seen), 32'd0);
        check("to_turn_stay", 32'(turn), 32'd2);
        pc_move(p, delay, 1'b0);
`endif
    endtask

    task automatic expect_over_idle();
        bit seen = 1'b0;
        rx_empty    = 1'b0;
        r_data      = 8'h31;
        pc_valid    = 1'b1;
        pc_position = 4'(random_free());
        repeat (5) begin
            cycle();
            seen |= (rd_uart | play | pc);
        end
        check("over_quiet", 32'(seen), 32'd0);
        check("over_flag", 32'(game_over), 32'd1);
        check("over_turn", 32'(turn), 32'd0);
        rx_empty = 1'b1;
        pc_valid = 1'b0;
    endtask

    task automatic do_start(input bit with_rx, input logic [7:0] b);
        rx_empty = !with_rx;
        r_data   = b;
        pc_valid = 1'b0;
        start    = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 1; i <= 9; i++) cells[i] = 2'b00;
        who       = 2'b00;
        mdl_count = 0;
        mdl_over  = 1'b0;
        check("start_turn", 32'(turn), 32'd1);
        check("start_count", 32'(move_count), 32'd0);
        check("start_bad", 32'(bad_move), 32'd0);
        check("start_over", 32'(game_over), 32'd0);
        check("start_no_pop", 32'(rd_uart), 32'd0);
    endtask

    task automatic random_game();
        do_start(1'b0, 8'h00);
        while (!mdl_over) begin
            mdl_ok = 1'b0;
            for (int t = 0; t < 6 && !mdl_ok; t++) begin
                player_move((t == 5) ? 8'(8'h30 + random_free()) : rand_byte(),
                            $urandom_range(0, 2));
            end
            if (mdl_over) break;
            if ($urandom_range(0, 3) == 0) begin
                pc_timeout_move($urandom_range(0, 2));
            end else begin
                mdl_ok = 1'b0;
                for (int t = 0; t < 4 && !mdl_ok; t++) begin
                    pc_move((t == 3) ? random_free() : $urandom_range(0, 15),
                            $urandom_range(0, 2), 1'($urandom_range(0, 1)));
                end
            end
        end
        expect_over_idle();
    endtask

    initial begin
        bit seen;
        for (int i = 1; i <= 9; i++) cells[i] = 2'b00;
        reset = 1'b1; start = 1'b0; rx_empty = 1'b1; pc_valid = 1'b0;
        r_data = 8'h00; pc_position = 4'd0; who = 2'b00;
        mdl_count = 0; mdl_ok = 1'b0; mdl_over = 1'b0;
        repeat (2) cycle();
        check_reset_values("reset_values");
        reset = 1'b0;
        rx_empty = 1'b0;
        r_data = 8'h35;
        repeat (2) cycle();
        check("idle_no_pop", 32'(rd_uart), 32'd0);
        check("idle_turn", 32'(turn), 32'd0);

        // Directed game following the turn protocol
        do_start(1'b0, 8'h00);
        player_move(8'h35, 1);
        pc_move(9, 0, 1'b1);
        player_move(8'h35, 0);
        player_move(8'h31, 0);
        pc_move(2, 0, 1'b0);
        player_move(8'h41, 0);
        player_move(8'h30, 0);
        check("rejects_keep_count", 32'(move_count), 32'd4);
        player_move(8'h33, 2);
        pc_timeout_move(0);
        player_move(8'h37, 0);
        check("win_over", 32'(mdl_over), 32'd1);
        expect_over_idle();
        do_start(1'b0, 8'h00);

        // Reset in the middle of a computer move
        player_move(8'h35, 0);
        pc_valid    = 1'b1;
        pc_position = 4'd1;
        cycle();
        #2 reset = 1'b1;
        #1 check_reset_values("reset_async");
        seen = 1'b0;
        repeat (3) begin
            cycle();
            seen |= (rd_uart | play | pc);
        end
        check("reset_no_strobe", 32'(seen), 32'd0);
        reset = 1'b0;
        pc_valid = 1'b0;
        rx_empty = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            cycle();
            seen |= (rd_uart | play | pc);
        end
        check("reset_idle_quiet", 32'(seen), 32'd0);
        check_reset_values("reset_idle_values");

        // Start together with a pending byte: start wins, pop happens next cycle
        do_start(1'b1, 8'h32);
        player_move(8'h32, 0);

        for (int g = 0; g < 6; g++) random_game();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
